// File: rtl/ctr_wait_monitor.sv
// Two-stage level-sensitive wait checker: waits for a non-zero counter, then for a target match,
// timestamping both hits. Optional abort after TIMEOUT wait cycles when CTR_WAIT_TIMEOUT_EN is defined.
module ctr_wait_monitor #(
  parameter int CTR_W   = 4,
  parameter int TS_W    = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CTR_W-1:0] target,
  input  logic [CTR_W-1:0] ctr,
  output logic             busy,
  output logic             hit_nz,
  output logic             hit_tgt,
  output logic [TS_W-1:0]  ts_nz,
  output logic [TS_W-1:0]  ts_tgt,
  output logic             done,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_NZ,
    WAIT_TGT,
    DONE
  } state_e;

  state_e             state_q;
  logic [CTR_W-1:0]   target_q;
  logic [TS_W-1:0]    tcount_q;
  logic [TS_W-1:0]    tcount_d;
  logic [TS_W-1:0]    ts_nz_q;
  logic [TS_W-1:0]    ts_tgt_q;
  logic               busy_q;
  logic               hit_nz_q;
  logic               hit_tgt_q;
  logic               done_q;
  logic               timeout_q;
  logic               nz_met;
  logic               tgt_met;

`ifdef CTR_WAIT_TIMEOUT_EN
  localparam logic [TS_W-1:0] TCOUNT_LAST = TS_W'(TIMEOUT - 1);
  logic               tmo_now;
  assign tmo_now = (tcount_q == TCOUNT_LAST);
`endif

  // The wait-cycle counter sticks at all-ones so a long wait never reports a small timestamp.
  assign tcount_d = (tcount_q == '1) ? tcount_q : tcount_q + TS_W'(1);
  assign nz_met   = (ctr != '0);
  assign tgt_met  = (ctr == target_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      target_q  <= '0;
      tcount_q  <= '0;
      ts_nz_q   <= '0;
      ts_tgt_q  <= '0;
      busy_q    <= 1'b0;
      hit_nz_q  <= 1'b0;
      hit_tgt_q <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      hit_nz_q  <= 1'b0;
      hit_tgt_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q   <= WAIT_NZ;
            target_q  <= target;
            tcount_q  <= '0;
            ts_nz_q   <= '0;
            ts_tgt_q  <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
          end
        end
        WAIT_NZ: begin
          tcount_q <= tcount_d;
          if (nz_met) begin
            ts_nz_q  <= tcount_q;
            hit_nz_q <= 1'b1;
            // Stage 2 is evaluated on the same edge, so an already-matching counter finishes at once.
            if (tgt_met) begin
              ts_tgt_q  <= tcount_q;
              hit_tgt_q <= 1'b1;
              state_q   <= DONE;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              state_q <= WAIT_TGT;
            end
          end
`ifdef CTR_WAIT_TIMEOUT_EN
          else if (tmo_now) begin
            state_q   <= DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end
`endif
        end
        WAIT_TGT: begin
          tcount_q <= tcount_d;
          if (tgt_met) begin
            ts_tgt_q  <= tcount_q;
            hit_tgt_q <= 1'b1;
            state_q   <= DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end
`ifdef CTR_WAIT_TIMEOUT_EN
          else if (tmo_now) begin
            state_q   <= DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end
`endif
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign hit_nz  = hit_nz_q;
  assign hit_tgt = hit_tgt_q;
  assign ts_nz   = ts_nz_q;
  assign ts_tgt  = ts_tgt_q;
  assign done    = done_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_ctr_wait_monitor.sv
// Scoreboard bench for ctr_wait_monitor: directed sequences push expected hit/done events,
// a negedge monitor pops and compares whenever the DUT pulses a hit or raises done.
module tb_ctr_wait_monitor;

  localparam int CTR_W = 4;
  localparam int TS_W  = 16;
`ifdef CTR_WAIT_TIMEOUT_EN
  localparam int TIMEOUT = 8;
`else
  localparam int TIMEOUT = 255;
`endif

  typedef struct packed {
    logic            hitNz;
    logic            hitTgt;
    logic [TS_W-1:0] tsNz;
    logic [TS_W-1:0] tsTgt;
    logic            done;
    logic            timeout;
  } event_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CTR_W-1:0] target;
  logic [CTR_W-1:0] ctr;
  logic             busy;
  logic             hit_nz;
  logic             hit_tgt;
  logic [TS_W-1:0]  ts_nz;
  logic [TS_W-1:0]  ts_tgt;
  logic             done;
  logic             timeout;

  int     errors = 0;
  int     checks = 0;
  event_t expQ[$];
  logic   donePrev = 1'b0;

  ctr_wait_monitor #(
    .CTR_W  (CTR_W),
    .TS_W   (TS_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .target (target),
    .ctr    (ctr),
    .busy   (busy),
    .hit_nz (hit_nz),
    .hit_tgt(hit_tgt),
    .ts_nz  (ts_nz),
    .ts_tgt (ts_tgt),
    .done   (done),
    .timeout(timeout)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Single comparison point shared by the stimulus and the monitor.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: any hit pulse or rising done is an output event that must match the queue head.
  always @(negedge clk) begin
    if (hit_nz || hit_tgt || (done && !donePrev)) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_event", {hit_nz, hit_tgt, done, timeout}, 32'd0);
      end else begin
        event_t e;
        e = expQ.pop_front();
        checkOutput("ev_hit_nz", 32'(hit_nz), 32'(e.hitNz));
        checkOutput("ev_hit_tgt", 32'(hit_tgt), 32'(e.hitTgt));
        checkOutput("ev_ts_nz", 32'(ts_nz), 32'(e.tsNz));
        checkOutput("ev_ts_tgt", 32'(ts_tgt), 32'(e.tsTgt));
        checkOutput("ev_done", 32'(done), 32'(e.done));
        checkOutput("ev_timeout", 32'(timeout), 32'(e.timeout));
      end
    end
    donePrev <= done;
  end

  // One active clock edge; inputs change 1 time unit after it.
  task automatic applyStimulus(input logic s, input logic [CTR_W-1:0] t, input logic [CTR_W-1:0] c);
    start  = s;
    target = t;
    ctr    = c;
    @(posedge clk);
    #1;
  endtask

  task automatic expectEvent(input logic hn, input logic ht, input int tn, input int tt,
                             input logic d, input logic to);
    event_t e;
    e.hitNz   = hn;
    e.hitTgt  = ht;
    e.tsNz    = TS_W'(tn);
    e.tsTgt   = TS_W'(tt);
    e.done    = d;
    e.timeout = to;
    expQ.push_back(e);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_timeout"}, 32'(timeout), 32'd0);
    checkOutput({tag, "_ts_nz"}, 32'(ts_nz), 32'd0);
    checkOutput({tag, "_ts_tgt"}, 32'(ts_tgt), 32'd0);
    checkOutput({tag, "_hits"}, 32'({hit_nz, hit_tgt}), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 4'd0, 4'd0);
    applyStimulus(1'b0, 4'd0, 4'd0);
    rst = 1'b0;
    checkAllZero("reset");

    // Counter activity without start must produce nothing.
    for (int v = 1; v <= 5; v++) applyStimulus(1'b0, 4'd4, CTR_W'(v));
    checkAllZero("idle");

    // Target 4: zero for three samples, then counting up; hits at tcount 3 and 6.
    applyStimulus(1'b1, 4'd4, 4'd0);
    checkOutput("a_busy_after_start", 32'(busy), 32'd1);
    applyStimulus(1'b0, 4'd0, 4'd0);
    applyStimulus(1'b0, 4'd0, 4'd0);
    applyStimulus(1'b0, 4'd0, 4'd0);
    expectEvent(1'b1, 1'b0, 3, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd0, 4'd1);
    applyStimulus(1'b0, 4'd0, 4'd2);
    applyStimulus(1'b0, 4'd0, 4'd3);
    expectEvent(1'b0, 1'b1, 3, 6, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'd0, 4'd4);
    applyStimulus(1'b0, 4'd0, 4'd9);
    applyStimulus(1'b0, 4'd0, 4'd0);
    checkOutput("a_done_held", 32'(done), 32'd1);
    checkOutput("a_ts_nz_held", 32'(ts_nz), 32'd3);
    checkOutput("a_ts_tgt_held", 32'(ts_tgt), 32'd6);
    checkOutput("a_busy_low", 32'(busy), 32'd0);

    // Back-to-back restart from DONE, counter already at target on the first sample.
    applyStimulus(1'b1, 4'd4, 4'd4);
    checkOutput("b_done_dropped", 32'(done), 32'd0);
    checkOutput("b_busy", 32'(busy), 32'd1);
    checkOutput("b_ts_cleared", 32'(ts_tgt), 32'd0);
    expectEvent(1'b1, 1'b1, 0, 0, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'd0, 4'd4);
    applyStimulus(1'b0, 4'd0, 4'd4);

    // Target 0 completes only when the counter wraps back to zero.
    applyStimulus(1'b1, 4'd0, 4'd7);
    expectEvent(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd0, 4'd1);
    for (int v = 2; v <= 15; v++) applyStimulus(1'b0, 4'd0, CTR_W'(v));
    expectEvent(1'b0, 1'b1, 0, 15, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'd0, 4'd0);
    applyStimulus(1'b0, 4'd0, 4'd0);

    // Reset while waiting for the target, then a clean second run with target 2.
    applyStimulus(1'b1, 4'd9, 4'd0);
    expectEvent(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd0, 4'd3);
    applyStimulus(1'b0, 4'd0, 4'd5);
    rst = 1'b1;
    applyStimulus(1'b1, 4'd9, 4'd9);
    checkAllZero("rst_mid");
    applyStimulus(1'b1, 4'd9, 4'd9);
    checkOutput("rst_beats_start", 32'(busy), 32'd0);
    rst = 1'b0;
    applyStimulus(1'b1, 4'd2, 4'd0);
    applyStimulus(1'b0, 4'd0, 4'd0);
    expectEvent(1'b1, 1'b0, 1, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd0, 4'd1);
    expectEvent(1'b0, 1'b1, 1, 2, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'd0, 4'd2);
    applyStimulus(1'b0, 4'd0, 4'd2);
    checkOutput("c_done", 32'(done), 32'd1);

`ifdef CTR_WAIT_TIMEOUT_EN
    // Counter stuck at zero aborts after the sample taken with tcount = TIMEOUT-1.
    applyStimulus(1'b1, 4'd4, 4'd0);
    for (int i = 0; i < TIMEOUT - 1; i++) applyStimulus(1'b0, 4'd0, 4'd0);
    checkOutput("t_not_yet", 32'(done), 32'd0);
    expectEvent(1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
    applyStimulus(1'b0, 4'd0, 4'd0);
    applyStimulus(1'b0, 4'd0, 4'd0);
    checkOutput("t_timeout_level", 32'(timeout), 32'd1);
`else
    applyStimulus(1'b0, 4'd0, 4'd0);
    checkOutput("timeout_tied", 32'(timeout), 32'd0);
`endif

    applyStimulus(1'b0, 4'd0, 4'd0);
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
